regfile_mp: RTL

Parametrised multi-port general-purpose register file for the tinyriscv core. It is the successor to the single-write, dual-read regs block and sits between ID (reads), EX/WB (writes) and the JTAG debug module.
- Adds N read ports and M write ports, each read port with write-to-read bypass.
- Adds a JTAG request/grant handshake with registered read data.
- Adds a starvation counter that stalls the pipeline so a pending JTAG write always completes.

---
 rtl/regfile_mp.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- multi-port general-purpose register file for the tinyriscv core
//
// Sits between ID (combinational read ports), EX/WB (core write ports) and the
// JTAG debug module (request/grant port with registered read data). A small
// starvation FSM raises stall_o when JTAG has been denied for STARVE_LIMIT
// consecutive cycles. This guarantees that a pending JTAG access is granted.
//
// Ports:
//   clk_i          clock
//   rst_ni         synchronous active-low reset
//   we_i           per-port core write enable            [NR_WRITE]
//   waddr_i        core write addresses, port k at [k*AW +: AW]
//   wdata_i        core write data, port k at [k*DATA_W +: DATA_W]
//   raddr_i        read addresses, port j at [j*AW +: AW]
//   rdata_o        combinational read data with write bypass
//   jtag_req_i     JTAG request, held until granted
//   jtag_we_i      JTAG direction (1 = write)
//   jtag_addr_i    JTAG register address
//   jtag_wdata_i   JTAG write data
//   jtag_gnt_o     JTAG access accepted this cycle
//   jtag_rvalid_o  one-cycle pulse the cycle after a granted JTAG read
//   jtag_rdata_o   registered JTAG read data, held until the next rvalid
//   stall_o        pipeline stall request (core write enables must be 0)
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int NR_READ      = 2,
    parameter int NR_WRITE     = 1,
    parameter int DATA_W       = 32,
    parameter int NUM_REGS     = 32,
    parameter int STARVE_LIMIT = 4,
    localparam int AW          = $clog2(NUM_REGS)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NR_WRITE-1:0]          we_i,
    input  logic [NR_WRITE*AW-1:0]       waddr_i,
    input  logic [NR_WRITE*DATA_W-1:0]   wdata_i,
    input  logic [NR_READ*AW-1:0]        raddr_i,
    output logic [NR_READ*DATA_W-1:0]    rdata_o,
    input  logic                         jtag_req_i,
    input  logic                         jtag_we_i,
    input  logic [AW-1:0]                jtag_addr_i,
    input  logic [DATA_W-1:0]            jtag_wdata_i,
    output logic                         jtag_gnt_o,
    output logic                         jtag_rvalid_o,
    output logic [DATA_W-1:0]            jtag_rdata_o,
    output logic                         stall_o
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2
    } state_e;

    state_e              state_reg, state_next;
    logic [CW-1:0]       cnt_reg, cnt_next;

    logic [DATA_W-1:0]   regs_reg [NUM_REGS];
    logic                jtag_rvalid_reg;
    logic [DATA_W-1:0]   jtag_rdata_reg;

    // Core write enables actually honoured. While stalled the core must not
    // write; if it does anyway, the JTAG access takes the cycle and the core
    // write is dropped (also hidden from the bypass path so reads stay
    // consistent with what gets stored).
    logic [NR_WRITE-1:0] we_eff;
    logic                jtag_wr;
    logic                jtag_rd;

    assign we_eff  = stall_o ? '0 : we_i;
    assign jtag_wr = jtag_gnt_o &  jtag_we_i;
    assign jtag_rd = jtag_gnt_o & ~jtag_we_i;

    // -------------------------------------------------------------------------
    // Starvation FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Starvation FSM: next-state logic
    // cnt counts consecutive denied request cycles; the cycle whose denial
    // brings it to STARVE_LIMIT moves the FSM to STALL.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (jtag_req_i && !jtag_gnt_o) begin
                    cnt_next   = CW'(1);
                    state_next = (STARVE_LIMIT <= 1) ? ST_STALL : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!jtag_req_i || jtag_gnt_o) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                    if (cnt_next == CW'(STARVE_LIMIT)) begin
                        state_next = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                if (!jtag_req_i || jtag_gnt_o) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Starvation FSM: outputs
    // stall_o is decoded purely from the state register, so it is glitch-free.
    // Grant is masked during reset so an in-flight request is simply dropped.
    // -------------------------------------------------------------------------
    always_comb begin
        stall_o    = (state_reg == ST_STALL);
        jtag_gnt_o = rst_ni & jtag_req_i & (~(|we_i) | (state_reg == ST_STALL));
    end

    // -------------------------------------------------------------------------
    // Register storage. Core ports are applied in ascending index order so the
    // highest-index port wins on an address collision. The JTAG write is
    // applied last; it can only coincide with a core write during a stall,
    // where core writes are already masked.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NR_WRITE; k++) begin
                if (we_eff[k] && (waddr_i[k*AW +: AW] != '0)) begin
                    regs_reg[waddr_i[k*AW +: AW]] <= wdata_i[k*DATA_W +: DATA_W];
                end
            end
            if (jtag_wr && (jtag_addr_i != '0)) begin
                regs_reg[jtag_addr_i] <= jtag_wdata_i;
            end
        end
    end

    // -------------------------------------------------------------------------
    // JTAG read path. Samples the stored array, so a core write committing in
    // the same cycle is not seen (pre-write data).
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            jtag_rvalid_reg <= 1'b0;
            jtag_rdata_reg  <= '0;
        end else begin
            jtag_rvalid_reg <= jtag_rd;
            if (jtag_rd) begin
                jtag_rdata_reg <= (jtag_addr_i == '0) ? '0 : regs_reg[jtag_addr_i];
            end
        end
    end

    assign jtag_rvalid_o = jtag_rvalid_reg;
    assign jtag_rdata_o  = jtag_rdata_reg;

    // -------------------------------------------------------------------------
    // Combinational read ports with core-write bypass (highest port wins).
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NR_READ; gi++) begin : g_rd
            logic [AW-1:0]     ra;
            logic [DATA_W-1:0] rd;

            assign ra = raddr_i[gi*AW +: AW];

            always_comb begin
                rd = regs_reg[ra];
                for (int k = 0; k < NR_WRITE; k++) begin
                    if (we_eff[k] && (waddr_i[k*AW +: AW] == ra)) begin
                        rd = wdata_i[k*DATA_W +: DATA_W];
                    end
                end
                if (ra == '0) begin
                    rd = '0;
                end
            end

            assign rdata_o[gi*DATA_W +: DATA_W] = rd;
        end
    endgenerate

    // The core must hold its write enables low while a stall is requested.
    a_no_write_in_stall : assert property (
        @(posedge clk_i) disable iff (!rst_ni) stall_o |-> (we_i == '0)
    );

endmodule
